// File: rtl/usb_bulk_pkg.sv
// Shared definitions for the bulk IN endpoint path: FSM encoding, ZLP marker,
// standard max-packet sizes and the packet byte-counter width helper.
package usb_bulk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_ZLP      = 2'd2,
    ST_WAIT_END = 2'd3
  } bulk_in_state_e;

  // A ZLP is signalled to the TLP as a single cycle of valid=0 with last=1.
  localparam logic ZLP_MARK_VALID = 1'b0;
  localparam logic ZLP_MARK_LAST  = 1'b1;

  localparam int HS_MAX_PACKET = 512;
  localparam int FS_MAX_PACKET = 64;

  function automatic int pkt_cnt_width(input int max_pkt);
    return (max_pkt > 1) ? $clog2(max_pkt) : 1;
  endfunction

endpackage

// File: rtl/bulk_ep_in_pktzr.sv
// Per-packet byte counter for the selected channel: generates packet-end
// and reports whether the closing beat leaves a ZLP owed to the host.
module bulk_ep_in_pktzr
  import usb_bulk_pkg::*;
#(
  parameter int MAX_PACKET_SIZE = HS_MAX_PACKET,
  parameter bit ZLP_ENABLE      = 1'b1
) (
  input  logic usb_clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic beat_i,
  input  logic src_last_i,
  output logic pkt_last_o,
  output logic zlp_next_o
);

  localparam int CW = pkt_cnt_width(MAX_PACKET_SIZE);
  localparam logic [CW-1:0] CNT_TOP = CW'(MAX_PACKET_SIZE - 1);

  logic [CW-1:0] count_q, count_d;
  logic          at_top;

  assign at_top     = (count_q == CNT_TOP);
  assign pkt_last_o = src_last_i | at_top;
  // Frame ending exactly on a full packet means the host cannot tell it ended.
  assign zlp_next_o = ZLP_ENABLE & at_top & src_last_i;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (beat_i) begin
      count_d = pkt_last_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bulk_ep_in_mux.sv
// Multi-channel bulk IN endpoint mux: maps endpoints EP_BASE.. onto AXIS byte
// sources, splits frames into packets, emits ZLPs. Optional: BULK_EP_IN_MUX_STATS_EN.
module bulk_ep_in_mux
  import usb_bulk_pkg::*;
#(
  parameter int NUM_CHAN        = 2,
  parameter int EP_BASE         = 1,
  parameter int MAX_PACKET_SIZE = HS_MAX_PACKET,
  parameter bit ZLP_ENABLE      = 1'b1
) (
  input  logic                  usb_clk,
  input  logic                  reset_n,
  input  logic [3:0]            blk_xfer_endpoint,
  input  logic                  blk_in_xfer,
  output logic                  blk_xfer_in_has_data,
  output logic [7:0]            blk_xfer_in_data,
  output logic                  blk_xfer_in_data_valid,
  input  logic                  blk_xfer_in_data_ready,
  output logic                  blk_xfer_in_data_last,
  input  logic [NUM_CHAN-1:0]   s_axis_tvalid,
  output logic [NUM_CHAN-1:0]   s_axis_tready,
  input  logic [8*NUM_CHAN-1:0] s_axis_tdata,
  input  logic [NUM_CHAN-1:0]   s_axis_tlast
`ifdef BULK_EP_IN_MUX_STATS_EN
  ,
  output logic [16*NUM_CHAN-1:0] stat_pkt_count
`endif
);

  localparam logic [4:0] EP_LO    = 5'(EP_BASE);
  localparam logic [4:0] EP_HI    = 5'(EP_BASE + NUM_CHAN);
  localparam logic [3:0] EP_BASE4 = 4'(EP_BASE);

  bulk_in_state_e      state_q, state_d;
  logic [3:0]          sel_q, sel_d;
  logic [NUM_CHAN-1:0] zlp_pending_q, zlp_pending_d;

  logic       in_range;
  logic [3:0] ch;
  logic       ch_tvalid, ch_zlp;
  logic       sel_tvalid, sel_tlast;
  logic [7:0] sel_tdata;
  logic       stream_go, beat, pkt_clr, pkt_done;
  logic       pkt_last, zlp_next;

  assign in_range = ({1'b0, blk_xfer_endpoint} >= EP_LO) &&
                    ({1'b0, blk_xfer_endpoint} <  EP_HI);
  assign ch       = blk_xfer_endpoint - EP_BASE4;

  always_comb begin
    ch_tvalid  = 1'b0;
    ch_zlp     = 1'b0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tdata  = 8'h00;
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (ch == 4'(c)) begin
        ch_tvalid = s_axis_tvalid[c];
        ch_zlp    = zlp_pending_q[c];
      end
      if (sel_q == 4'(c)) begin
        sel_tvalid = s_axis_tvalid[c];
        sel_tlast  = s_axis_tlast[c];
        sel_tdata  = s_axis_tdata[8*c +: 8];
      end
    end
  end

  assign blk_xfer_in_has_data = in_range & (ch_tvalid | ch_zlp);

  bulk_ep_in_pktzr #(
    .MAX_PACKET_SIZE (MAX_PACKET_SIZE),
    .ZLP_ENABLE      (ZLP_ENABLE)
  ) u_pktzr (
    .usb_clk    (usb_clk),
    .reset_n    (reset_n),
    .clr_i      (pkt_clr),
    .beat_i     (beat),
    .src_last_i (sel_tlast),
    .pkt_last_o (pkt_last),
    .zlp_next_o (zlp_next)
  );

  always_comb begin
    state_d                = state_q;
    sel_d                  = sel_q;
    zlp_pending_d          = zlp_pending_q;
    blk_xfer_in_data       = 8'h00;
    blk_xfer_in_data_valid = 1'b0;
    blk_xfer_in_data_last  = 1'b0;
    stream_go              = 1'b0;
    beat                   = 1'b0;
    pkt_clr                = 1'b1;
    pkt_done               = 1'b0;
    // Everything is held quiet while reset is asserted, even mid-packet.
    if (reset_n) begin
      unique case (state_q)
        ST_IDLE: begin
          if (blk_in_xfer) begin
            if (!in_range) begin
              state_d = ST_WAIT_END;
            end else begin
              sel_d = ch;
              if (ch_zlp)         state_d = ST_ZLP;
              else if (ch_tvalid) state_d = ST_STREAM;
              else                state_d = ST_WAIT_END;
            end
          end
        end
        ST_STREAM: begin
          if (!blk_in_xfer) begin
            state_d = ST_IDLE;
          end else begin
            stream_go              = 1'b1;
            pkt_clr                = 1'b0;
            blk_xfer_in_data       = sel_tdata;
            blk_xfer_in_data_valid = sel_tvalid;
            // Qualified by valid so a stall is never mistaken for the ZLP marker.
            blk_xfer_in_data_last  = sel_tvalid & pkt_last;
            beat                   = sel_tvalid & blk_xfer_in_data_ready;
            if (beat && pkt_last) begin
              for (int c = 0; c < NUM_CHAN; c++) begin
                if (sel_q == 4'(c)) zlp_pending_d[c] = zlp_next;
              end
              pkt_done = 1'b1;
              state_d  = ST_WAIT_END;
            end
          end
        end
        ST_ZLP: begin
          if (!blk_in_xfer) begin
            state_d = ST_IDLE;
          end else begin
            blk_xfer_in_data_valid = ZLP_MARK_VALID;
            blk_xfer_in_data_last  = ZLP_MARK_LAST;
            for (int c = 0; c < NUM_CHAN; c++) begin
              if (sel_q == 4'(c)) zlp_pending_d[c] = 1'b0;
            end
            pkt_done = 1'b1;
            state_d  = ST_WAIT_END;
          end
        end
        ST_WAIT_END: begin
          if (!blk_in_xfer) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_tready
    assign s_axis_tready[gi] = stream_go & (sel_q == 4'(gi)) & blk_xfer_in_data_ready;
  end

  always_ff @(posedge usb_clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= 4'd0;
      zlp_pending_q <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      zlp_pending_q <= zlp_pending_d;
    end
  end

`ifdef BULK_EP_IN_MUX_STATS_EN
  for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_stat
    logic [15:0] pkt_cnt_q;
    always_ff @(posedge usb_clk) begin
      if (!reset_n) begin
        pkt_cnt_q <= 16'd0;
      end else if (pkt_done && (sel_q == 4'(gi))) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
    end
    assign stat_pkt_count[16*gi +: 16] = pkt_cnt_q;
  end
`endif

endmodule

// File: tb/tb_bulk_ep_in_mux.sv
// Directed bench for bulk_ep_in_mux (MAX_PACKET_SIZE=8): one DUT with ZLPs on,
// one with ZLPs off, sharing the per-channel byte sources.
module tb_bulk_ep_in_mux;

  logic        usb_clk = 1'b0;
  logic        reset_n;
  logic [3:0]  ep;
  logic        xfer_a, xfer_b, tlp_ready;
  logic [1:0]  s_tvalid, s_tlast;
  logic [15:0] s_tdata;

  logic        has_a, valid_a, last_a, has_b, valid_b, last_b;
  logic [7:0]  data_a, data_b;
  logic [1:0]  tready_a, tready_b;
`ifdef BULK_EP_IN_MUX_STATS_EN
  logic [31:0] stat_a, stat_b;
`endif

  always #5 usb_clk = ~usb_clk;

  bulk_ep_in_mux #(.NUM_CHAN(2), .EP_BASE(1), .MAX_PACKET_SIZE(8), .ZLP_ENABLE(1'b1)) dut_a (
    .usb_clk(usb_clk), .reset_n(reset_n), .blk_xfer_endpoint(ep), .blk_in_xfer(xfer_a),
    .blk_xfer_in_has_data(has_a), .blk_xfer_in_data(data_a), .blk_xfer_in_data_valid(valid_a),
    .blk_xfer_in_data_ready(tlp_ready), .blk_xfer_in_data_last(last_a),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(tready_a), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast)
`ifdef BULK_EP_IN_MUX_STATS_EN
    , .stat_pkt_count(stat_a)
`endif
  );

  bulk_ep_in_mux #(.NUM_CHAN(2), .EP_BASE(1), .MAX_PACKET_SIZE(8), .ZLP_ENABLE(1'b0)) dut_b (
    .usb_clk(usb_clk), .reset_n(reset_n), .blk_xfer_endpoint(ep), .blk_in_xfer(xfer_b),
    .blk_xfer_in_has_data(has_b), .blk_xfer_in_data(data_b), .blk_xfer_in_data_valid(valid_b),
    .blk_xfer_in_data_ready(tlp_ready), .blk_xfer_in_data_last(last_b),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(tready_b), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast)
`ifdef BULK_EP_IN_MUX_STATS_EN
    , .stat_pkt_count(stat_b)
`endif
  );

  int         errors = 0;
  int         checks = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] rx_q[$];
  int         n_last, zlp_seen;
  logic       any_tready;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    s_tvalid = 2'b00; s_tlast = 2'b00; s_tdata = 16'h0000;
    if (q0.size() != 0) begin
      s_tvalid[0] = 1'b1; s_tlast[0] = q0[0][8]; s_tdata[7:0] = q0[0][7:0];
    end
    if (q1.size() != 0) begin
      s_tvalid[1] = 1'b1; s_tlast[1] = q1[0][8]; s_tdata[15:8] = q1[0][7:0];
    end
  endtask

  // One clock: handshakes sampled just before the edge, sources advanced after it.
  task automatic tick();
    logic pop0, pop1;
    #1;
    pop0 = s_tvalid[0] & (tready_a[0] | tready_b[0]);
    pop1 = s_tvalid[1] & (tready_a[1] | tready_b[1]);
    @(posedge usb_clk);
    #1;
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    refresh();
    @(negedge usb_clk);
  endtask

  task automatic push_frame(input int c, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (c == 0) q0.push_back({(i == n - 1), 8'(base + i)});
      else        q1.push_back({(i == n - 1), 8'(base + i)});
    end
    refresh();
  endtask

  task automatic in_xact(input logic [3:0] e, input bit use_b, input int abort_after, input int budget);
    logic v, l, done;
    logic [7:0] d;
    rx_q.delete(); n_last = 0; zlp_seen = 0; any_tready = 1'b0;
    ep = e; tlp_ready = 1'b1;
    if (use_b) xfer_b = 1'b1; else xfer_a = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      #1;
      v = use_b ? valid_b : valid_a;
      l = use_b ? last_b : last_a;
      d = use_b ? data_b : data_a;
      any_tready = any_tready | ((use_b ? tready_b : tready_a) != 2'b00);
      done = 1'b0;
      if (v && tlp_ready) begin
        rx_q.push_back(d);
        if (l) begin n_last++; done = 1'b1; end
        if (abort_after > 0 && rx_q.size() == abort_after) done = 1'b1;
      end else if (l && !v) begin
        zlp_seen++; done = 1'b1;
      end
      tick();
      if (done) break;
    end
    xfer_a = 1'b0; xfer_b = 1'b0; tlp_ready = 1'b0;
    tick(); tick();
    $display("IN dut=%s ep=%0d bytes=%0d lasts=%0d zlp=%0d", use_b ? "b" : "a", e, rx_q.size(), n_last, zlp_seen);
  endtask

  task automatic check_rx(input string tag, input int n, input logic [7:0] base, input int nl, input int nz);
    chk({tag, "_len"}, rx_q.size(), n);
    chk({tag, "_lasts"}, n_last, nl);
    chk({tag, "_zlp"}, zlp_seen, nz);
    for (int i = 0; i < n && i < rx_q.size(); i++) chk({tag, "_data"}, rx_q[i], 8'(base + i));
  endtask

  task automatic chk_has(input string tag, input logic [3:0] e, input bit use_b, input logic exp);
    ep = e; #1;
    chk(tag, use_b ? has_b : has_a, exp);
  endtask

  initial begin
    reset_n = 1'b0; ep = 4'd1; xfer_a = 1'b0; xfer_b = 1'b0; tlp_ready = 1'b0;
    refresh();
    @(negedge usb_clk);
    tick(); tick();
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_last", last_a, 1'b0);
    chk("rst_tready", tready_a, 2'b00);
    chk_has("rst_has", 4'd1, 1'b0, 1'b0);
`ifdef BULK_EP_IN_MUX_STATS_EN
    chk("rst_stat", stat_a, 32'h0);
`endif
    reset_n = 1'b1;
    tick();

    // Short frame on channel 0: one packet, no ZLP.
    push_frame(0, 8'hA0, 5);
    chk_has("t1_has", 4'd1, 1'b0, 1'b1);
    in_xact(4'd1, 1'b0, 0, 20);
    check_rx("t1", 5, 8'hA0, 1, 0);
    chk_has("t1_has_after", 4'd1, 1'b0, 1'b0);

    // 16 bytes on channel 1: two full packets then a ZLP.
    push_frame(1, 8'hB0, 16);
    in_xact(4'd2, 1'b0, 0, 20);
    check_rx("t2_p1", 8, 8'hB0, 1, 0);
    in_xact(4'd2, 1'b0, 0, 20);
    check_rx("t2_p2", 8, 8'hB8, 1, 0);
    chk_has("t2_has_zlp", 4'd2, 1'b0, 1'b1);
    in_xact(4'd2, 1'b0, 0, 20);
    check_rx("t2_zlp", 0, 8'h00, 0, 1);
    chk_has("t2_has_after", 4'd2, 1'b0, 1'b0);
`ifdef BULK_EP_IN_MUX_STATS_EN
    chk("t2_stat_ch0", stat_a[15:0], 32'd1);
    chk("t2_stat_ch1", stat_a[31:16], 32'd3);
`endif

    // Same frame with ZLPs disabled.
    push_frame(1, 8'hC0, 16);
    in_xact(4'd2, 1'b1, 0, 20);
    check_rx("t3_p1", 8, 8'hC0, 1, 0);
    in_xact(4'd2, 1'b1, 0, 20);
    check_rx("t3_p2", 8, 8'hC8, 1, 0);
    chk_has("t3_has_after", 4'd2, 1'b1, 1'b0);
    in_xact(4'd2, 1'b1, 0, 6);
    check_rx("t3_nak", 0, 8'h00, 0, 0);

    // Out-of-range endpoints while channel 0 holds data.
    push_frame(0, 8'hD0, 10);
    chk_has("t4_has_ep5", 4'd5, 1'b0, 1'b0);
    chk_has("t4_has_ep0", 4'd0, 1'b0, 1'b0);
    in_xact(4'd5, 1'b0, 0, 6);
    check_rx("t4", 0, 8'h00, 0, 0);
    chk("t4_tready", any_tready, 1'b0);

    // Abort after three bytes; the retry restarts the packet count.
    in_xact(4'd1, 1'b0, 3, 20);
    check_rx("t5_abort", 3, 8'hD0, 0, 0);
    chk_has("t5_has", 4'd1, 1'b0, 1'b1);
    in_xact(4'd1, 1'b0, 0, 20);
    check_rx("t5_rest", 7, 8'hD3, 1, 0);

    // Reset during a stream on channel 0 while channel 1 owes a ZLP.
    push_frame(1, 8'hE0, 8);
    in_xact(4'd2, 1'b0, 0, 20);
    check_rx("t6_full", 8, 8'hE0, 1, 0);
    chk_has("t6_has_zlp", 4'd2, 1'b0, 1'b1);
    push_frame(0, 8'hF0, 4);
    ep = 4'd1; xfer_a = 1'b1; tlp_ready = 1'b1;
    tick();
    chk("t6_stream_valid", valid_a, 1'b1);
    chk("t6_stream_data", data_a, 8'hF0);
    tick();
    reset_n = 1'b0;
    #1;
    chk("t6_rst_cycle_tready", tready_a, 2'b00);
    tick();
    chk("t6_rst_valid", valid_a, 1'b0);
    chk("t6_rst_last", last_a, 1'b0);
    chk("t6_rst_tready", tready_a, 2'b00);
    xfer_a = 1'b0; tlp_ready = 1'b0;
    chk_has("t6_rst_zlp_clr", 4'd2, 1'b0, 1'b0);
`ifdef BULK_EP_IN_MUX_STATS_EN
    chk("t6_rst_stat", stat_a, 32'h0);
`endif
    reset_n = 1'b1;
    tick();
    chk_has("t6_has_ch0", 4'd1, 1'b0, 1'b1);
    in_xact(4'd1, 1'b0, 0, 20);
    check_rx("t6_rest", 3, 8'hF1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
